buffer_fifo_sequencer: RTL

Controller that sequences one `buffer_fifo_configurable` instance as an image row-delay line. It resets and configures the FIFO for 1–4 active sub-buffers, fills it from a valid/ready pixel stream, then runs steady-state pop→internal-shift→push cycles. Each delayed pixel is presented with a valid strobe. It sits between the pixel source and the filter window logic.

---
 rtl/buffer_fifo_sequencer.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/buffer_fifo_sequencer.sv
// Row-delay controller: configures a buffer_fifo_configurable, fills it,
// then streams pop -> internal shift -> push cycles, strobing each delayed pixel.
module buffer_fifo_sequencer #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned UNIT_DEPTH  = 16,
  parameter int unsigned CFG_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cfg_start,
  input  logic [2:0]            cfg_units,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  input  logic [DATA_WIDTH-1:0] pix_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [7:0]            col_count,
  output logic [7:0]            row_count,
  output logic                  busy,
  output logic                  cfg_error,
  output logic                  fifo_reset_config,
  output logic                  fifo_reset_data,
  output logic [2:0]            fifo_configuration,
  output logic                  fifo_push,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_full,
  input  logic                  fifo_no_config
);

  localparam int unsigned MAX_ROW = 4 * UNIT_DEPTH;
  localparam int unsigned CNT_W   = $clog2(MAX_ROW + 1);
  localparam int unsigned TMO_W   = $clog2(CFG_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_CFG, S_FILL, S_STREAM, S_SHIFT, S_PUSH
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [2:0]            r_units;
  logic [DATA_WIDTH-1:0] r_hold;
  logic [CNT_W-1:0]      r_fill_cnt;
  logic [TMO_W-1:0]      r_tmo;
  logic [7:0]            r_col;
  logic [7:0]            r_row;
  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic                  r_busy;
  logic                  r_err;
  logic                  r_rst_cfg;
  logic                  r_rst_data;
  logic [2:0]            r_cfg_code;

  logic                  w_units_ok;
  logic [CNT_W-1:0]      w_row_len;
  logic                  w_tmo_hit;

  assign w_units_ok = (cfg_units != 3'd0) && (cfg_units <= 3'd4);
  assign w_row_len  = CNT_W'(r_units) * CNT_W'(UNIT_DEPTH);
  assign w_tmo_hit  = (r_tmo == TMO_W'(CFG_TIMEOUT - 1));

  assign out_valid          = r_out_valid;
  assign out_data           = r_out_data;
  assign col_count          = r_col;
  assign row_count          = r_row;
  assign busy               = r_busy;
  assign cfg_error          = r_err;
  assign fifo_reset_config  = r_rst_cfg;
  assign fifo_reset_data    = r_rst_data;
  assign fifo_configuration = r_cfg_code;

  // Next-state selection; cfg_start aborts from any state.
  always_comb begin
    w_next = r_state;
    if (cfg_start) begin
      w_next = w_units_ok ? S_RST : S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_next = S_IDLE;
        S_RST:    w_next = S_CFG;
        S_CFG: begin
          if (!fifo_no_config)  w_next = S_FILL;
          else if (w_tmo_hit)   w_next = S_IDLE;
        end
        S_FILL:   if (fifo_full) w_next = S_STREAM;
        S_STREAM: if (pix_valid) w_next = S_SHIFT;
        S_SHIFT:  w_next = S_PUSH;
        S_PUSH:   w_next = S_STREAM;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  // Handshake and FIFO strobes decoded from state and live inputs.
  always_comb begin
    pix_ready    = 1'b0;
    fifo_push    = 1'b0;
    fifo_pop     = 1'b0;
    fifo_data_in = '0;
    case (r_state)
      S_FILL: begin
        pix_ready    = !fifo_full;
        fifo_push    = pix_valid && !fifo_full;
        fifo_data_in = pix_data;
      end
      S_STREAM: begin
        pix_ready = 1'b1;
        fifo_pop  = pix_valid;
      end
      S_PUSH: begin
        fifo_push    = 1'b1;
        fifo_data_in = r_hold;
      end
      default: ;
    endcase
  end

  // State register plus all registered outputs and counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_units     <= 3'd0;
      r_hold      <= '0;
      r_fill_cnt  <= '0;
      r_tmo       <= '0;
      r_col       <= 8'd0;
      r_row       <= 8'd0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
      r_rst_cfg   <= 1'b1;
      r_rst_data  <= 1'b1;
      r_cfg_code  <= 3'd0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= 1'b0;
      r_busy      <= (w_next != S_IDLE);
      r_rst_cfg   <= (w_next == S_IDLE) || (w_next == S_RST);
      r_rst_data  <= (w_next == S_IDLE) || (w_next == S_RST);
      r_cfg_code  <= ((w_next == S_IDLE) || (w_next == S_RST)) ? 3'd0 : r_units;
      if (cfg_start) begin
        if (w_units_ok) begin
          r_units    <= cfg_units;
          r_fill_cnt <= '0;
          r_tmo      <= '0;
          r_col      <= 8'd0;
          r_row      <= 8'd0;
        end else begin
          r_err <= 1'b1;
        end
      end else begin
        case (r_state)
          S_CFG: begin
            if (fifo_no_config) begin
              if (w_tmo_hit) r_err <= 1'b1;
              else           r_tmo <= r_tmo + TMO_W'(1);
            end
          end
          S_FILL: begin
            if (fifo_full) begin
              if (r_fill_cnt != w_row_len) r_err <= 1'b1;
            end else if (pix_valid) begin
              r_fill_cnt <= r_fill_cnt + CNT_W'(1);
            end
          end
          S_STREAM: if (pix_valid) r_hold <= pix_data;
          S_SHIFT: begin
            r_out_valid <= 1'b1;
            r_out_data  <= fifo_data_out;
          end
          S_PUSH: begin
            // out_valid is high during PUSH; advance the column after the strobe.
            if (r_col == 8'(w_row_len - CNT_W'(1))) begin
              r_col <= 8'd0;
              if (r_row != 8'hFF) r_row <= r_row + 8'd1;
            end else begin
              r_col <= r_col + 8'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
